reg_file_mp: RTL and testbench

Parametrised multi-port register file, successor to the single-port 8-bit file in the datapath.
- One write port and two independent read ports, so the ALU can fetch both operands in one cycle.
- Dedicated flags-update port, so the ALU writes flags alongside a result.
- Per-register busy scoreboard, so the sequencer can stall on pending results.
- Optional write-to-read bypass.

---
 rtl/reg_file_mp_pkg.sv | 9 +
 rtl/rf_scoreboard.sv | 39 +++
 rtl/reg_file_mp.sv | 57 +++++
 tb/tb_reg_file_mp.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/reg_file_mp_pkg.sv
// reg_file_mp_pkg: shared constants and types for the multi-port register file.
package reg_file_mp_pkg;
    localparam int FLAGS_IDX_DEF = 3;
    localparam int FLAG_Z = 0;
    localparam int FLAG_C = 1;
    localparam int FLAG_N = 2;
    localparam int FLAG_V = 3;
    typedef logic [1:0] reg_idx_t;
endpackage

// File: rtl/rf_scoreboard.sv
// rf_scoreboard: per-register busy bits with reserve-over-clear priority and busy lookup.
module rf_scoreboard
    import reg_file_mp_pkg::*;
#(
    parameter int NREGS = 4,
    parameter int BYPASS = 1,
    localparam int AW = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rsv_en,
    input  logic [AW-1:0]    rsv_idx,
    input  logic             wr,
    input  logic [AW-1:0]    waddr,
    input  logic [AW-1:0]    raddr_a,
    input  logic [AW-1:0]    raddr_b,
    output logic             busy_a,
    output logic             busy_b,
    output logic [NREGS-1:0] busy_vec
);
    localparam logic [AW:0] NR = (AW+1)'(NREGS);
    logic [NREGS-1:0] busy;
    logic rok;
    assign rok = rsv_en && ({1'b0, rsv_idx} < NR);
    // Reserve is applied last so a new producer wins over a same-cycle retire.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= '0;
        end else begin
            if (wr) busy[waddr] <= 1'b0;
            if (rok) busy[rsv_idx] <= 1'b1;
        end
    end
    assign busy_vec = busy;
    assign busy_a = (BYPASS != 0 && wr && waddr == raddr_a) ? 1'b0 :
                    ({1'b0, raddr_a} < NR) ? busy[raddr_a] : 1'b0;
    assign busy_b = (BYPASS != 0 && wr && waddr == raddr_b) ? 1'b0 :
                    ({1'b0, raddr_b} < NR) ? busy[raddr_b] : 1'b0;
endmodule

// File: rtl/reg_file_mp.sv
// reg_file_mp: register file with one write port, two read ports, a flags-update port
// and a busy scoreboard; optional same-cycle write bypass.
module reg_file_mp
    import reg_file_mp_pkg::*;
#(
    parameter int NREGS = 4,
    parameter int WIDTH = 8,
    parameter int FLAGS_IDX = FLAGS_IDX_DEF,
    parameter int BYPASS = 1,
    localparam int AW = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr_a,
    output logic [WIDTH-1:0] rdata_a,
    input  logic [AW-1:0]    raddr_b,
    output logic [WIDTH-1:0] rdata_b,
    input  logic             flag_we,
    input  logic [WIDTH-1:0] flag_val,
    input  logic             rsv_en,
    input  logic [AW-1:0]    rsv_idx,
    output logic             busy_a,
    output logic             busy_b,
    output logic [NREGS-1:0] busy_vec
);
    localparam logic [AW:0] NR = (AW+1)'(NREGS);
    localparam logic [AW-1:0] FI = AW'(FLAGS_IDX);
    logic [WIDTH-1:0] regs [NREGS];
    logic wok, fok;
    assign wok = we && ({1'b0, waddr} < NR);
    assign fok = flag_we && !(wok && waddr == FI);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else begin
            if (fok) regs[FLAGS_IDX] <= flag_val;
            if (wok) regs[waddr] <= wdata;
        end
    end
    // Bypass is suppressed during reset so reads show the cleared state.
    assign rdata_a = rst ? '0 :
                     (BYPASS != 0 && wok && waddr == raddr_a) ? wdata :
                     (BYPASS != 0 && fok && raddr_a == FI) ? flag_val :
                     ({1'b0, raddr_a} < NR) ? regs[raddr_a] : '0;
    assign rdata_b = rst ? '0 :
                     (BYPASS != 0 && wok && waddr == raddr_b) ? wdata :
                     (BYPASS != 0 && fok && raddr_b == FI) ? flag_val :
                     ({1'b0, raddr_b} < NR) ? regs[raddr_b] : '0;
    rf_scoreboard #(.NREGS(NREGS), .BYPASS(BYPASS)) u_sb (
        .clk(clk), .rst(rst), .rsv_en(rsv_en), .rsv_idx(rsv_idx),
        .wr(wok), .waddr(waddr), .raddr_a(raddr_a), .raddr_b(raddr_b),
        .busy_a(busy_a), .busy_b(busy_b), .busy_vec(busy_vec)
    );
endmodule

// File: tb/tb_reg_file_mp.sv
// tb_reg_file_mp: directed checks of reg_file_mp with bypass on/off and a 5-entry 16-bit configuration.
module tb_reg_file_mp;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic we = 1'b0, flag_we = 1'b0, rsv_en = 1'b0;
    logic [1:0] waddr = '0, raddr_a = '0, raddr_b = '0, rsv_idx = '0;
    logic [7:0] wdata = '0, flag_val = '0;
    logic [7:0] rd_a0, rd_b0, rd_a1, rd_b1;
    logic ba0, bb0, ba1, bb1;
    logic [3:0] bv0, bv1;
    logic we2 = 1'b0, flag_we2 = 1'b0, rsv_en2 = 1'b0;
    logic [2:0] waddr2 = '0, raddr_a2 = '0, raddr_b2 = '0, rsv_idx2 = '0;
    logic [15:0] wdata2 = '0, flag_val2 = '0, rd_a2, rd_b2;
    logic ba2, bb2;
    logic [4:0] bv2;
    int total = 0;
    int passed = 0;

    always #5 clk = ~clk;

    reg_file_mp #(.BYPASS(1)) d0 (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr_a(raddr_a), .rdata_a(rd_a0), .raddr_b(raddr_b), .rdata_b(rd_b0),
        .flag_we(flag_we), .flag_val(flag_val), .rsv_en(rsv_en), .rsv_idx(rsv_idx),
        .busy_a(ba0), .busy_b(bb0), .busy_vec(bv0)
    );
    reg_file_mp #(.BYPASS(0)) d1 (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr_a(raddr_a), .rdata_a(rd_a1), .raddr_b(raddr_b), .rdata_b(rd_b1),
        .flag_we(flag_we), .flag_val(flag_val), .rsv_en(rsv_en), .rsv_idx(rsv_idx),
        .busy_a(ba1), .busy_b(bb1), .busy_vec(bv1)
    );
    reg_file_mp #(.NREGS(5), .WIDTH(16), .FLAGS_IDX(4), .BYPASS(1)) d2 (
        .clk(clk), .rst(rst), .we(we2), .waddr(waddr2), .wdata(wdata2),
        .raddr_a(raddr_a2), .rdata_a(rd_a2), .raddr_b(raddr_b2), .rdata_b(rd_b2),
        .flag_we(flag_we2), .flag_val(flag_val2), .rsv_en(rsv_en2), .rsv_idx(rsv_idx2),
        .busy_a(ba2), .busy_b(bb2), .busy_vec(bv2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
        // seed some state, then reset asynchronously mid-cycle
        we = 1'b1; waddr = 2'd0; wdata = 8'h77; rsv_en = 1'b1; rsv_idx = 2'd1;
        tick();
        we = 1'b0; rsv_en = 1'b0; raddr_a = 2'd0; raddr_b = 2'd0;
        #1;
        chk("seed_rdata", 32'(rd_a0), 32'h77);
        chk("seed_busy", 32'(bv0), 32'b0010);
        #1;
        rst = 1'b1; we = 1'b1; waddr = 2'd0; wdata = 8'h99;
        #1;
        chk("rst_rdata_a", 32'(rd_a0), 32'h00);
        chk("rst_rdata_b", 32'(rd_b0), 32'h00);
        chk("rst_busy_vec", 32'(bv0), 32'b0000);
        rst = 1'b0; we = 1'b0;
        #1;
        chk("post_rst_rdata", 32'(rd_a0), 32'h00);
        tick();
        // write then read on both ports
        we = 1'b1; waddr = 2'd1; wdata = 8'hA5; raddr_a = 2'd1; raddr_b = 2'd0;
        #1;
        chk("bypass_rdata_a", 32'(rd_a0), 32'hA5);
        chk("nobypass_rdata_a", 32'(rd_a1), 32'h00);
        tick();
        we = 1'b0;
        #1;
        chk("wr_rdata_a", 32'(rd_a0), 32'hA5);
        chk("wr_rdata_b", 32'(rd_b0), 32'h00);
        chk("nobypass_wr_rdata_a", 32'(rd_a1), 32'hA5);
        // general write beats same-cycle flags update
        we = 1'b1; waddr = 2'd3; wdata = 8'h11; flag_we = 1'b1; flag_val = 8'h80; raddr_a = 2'd3;
        #1;
        chk("flag_conflict_bypass", 32'(rd_a0), 32'h11);
        tick();
        we = 1'b0;
        #1;
        chk("flag_conflict_reg", 32'(rd_a1), 32'h11);
        chk("flag_bypass", 32'(rd_a0), 32'h80);
        tick();
        flag_we = 1'b0;
        #1;
        chk("flag_reg_d0", 32'(rd_a0), 32'h80);
        chk("flag_reg_d1", 32'(rd_a1), 32'h80);
        // scoreboard reserve and clear
        rsv_en = 1'b1; rsv_idx = 2'd2;
        tick();
        rsv_en = 1'b0; raddr_a = 2'd2; raddr_b = 2'd3;
        #1;
        chk("rsv_busy_vec", 32'(bv0), 32'b0100);
        chk("rsv_busy_a", 32'(ba0), 32'd1);
        chk("rsv_busy_b", 32'(bb0), 32'd0);
        we = 1'b1; waddr = 2'd2; wdata = 8'h42;
        #1;
        chk("wr_busy_a_bypass", 32'(ba0), 32'd0);
        chk("wr_busy_a_nobypass", 32'(ba1), 32'd1);
        tick();
        we = 1'b0;
        #1;
        chk("clr_busy_vec", 32'(bv0), 32'b0000);
        // flags update leaves busy untouched
        rsv_en = 1'b1; rsv_idx = 2'd3;
        tick();
        rsv_en = 1'b0; flag_we = 1'b1; flag_val = 8'h05;
        tick();
        flag_we = 1'b0;
        #1;
        chk("flag_keeps_busy", 32'(bv0), 32'b1000);
        we = 1'b1; waddr = 2'd3; wdata = 8'h00;
        tick();
        we = 1'b0;
        // reserve and write to the same index collide
        rsv_en = 1'b1; rsv_idx = 2'd2;
        tick();
        we = 1'b1; waddr = 2'd2; wdata = 8'h3C;
        tick();
        we = 1'b0; rsv_en = 1'b0; raddr_a = 2'd2;
        #1;
        chk("collide_rdata", 32'(rd_a0), 32'h3C);
        chk("collide_busy_vec", 32'(bv0), 32'b0100);
        // non-power-of-2 configuration
        we2 = 1'b1; waddr2 = 3'd6; wdata2 = 16'hDEAD; rsv_en2 = 1'b1; rsv_idx2 = 3'd7;
        tick();
        we2 = 1'b0; rsv_en2 = 1'b0;
        #1;
        chk("oor_busy_vec", 32'(bv2), 32'd0);
        for (int i = 0; i < 5; i++) begin
            raddr_a2 = 3'(i);
            #1;
            chk("oor_no_change", 32'(rd_a2), 32'h0000);
        end
        raddr_a2 = 3'd7; raddr_b2 = 3'd6;
        #1;
        chk("oor_rdata_a", 32'(rd_a2), 32'h0000);
        chk("oor_rdata_b", 32'(rd_b2), 32'h0000);
        chk("oor_busy_a", 32'(ba2), 32'd0);
        we2 = 1'b1; waddr2 = 3'd4; wdata2 = 16'hBEEF;
        tick();
        we2 = 1'b0; raddr_a2 = 3'd4;
        #1;
        chk("np2_readback", 32'(rd_a2), 32'hBEEF);
        flag_we2 = 1'b1; flag_val2 = 16'h1234;
        tick();
        flag_we2 = 1'b0;
        #1;
        chk("np2_flags", 32'(rd_a2), 32'h1234);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
